// File: rtl/lcd_src_scheduler_pkg.sv
// Shared definitions for the LCD source scheduler: FSM encoding, frame geometry,
// the blank character and the character-source numbering.
package lcd_src_scheduler_pkg;

    typedef enum logic [1:0] {
        SHOW  = 2'd0,
        PEND  = 2'd1,
        BLANK = 2'd2
    } sched_state_t;

    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam int         FRAME_LAST = 31;

    localparam logic [1:0] SRC_WATCH = 2'd0;
    localparam logic [1:0] SRC_SET   = 2'd1;
    localparam logic [1:0] SRC_ALARM = 2'd2;
    localparam logic [1:0] SRC_STOPW = 2'd3;

endpackage

// File: rtl/lcd_src_scheduler_if.sv
// Character-path bundle between the mode_* blocks, the scheduler and lcd_driver.
// The master drives requests and source data, the slave returns the selected character.
interface lcd_src_scheduler_if #(
    parameter int NSRC   = 4,
    parameter int CHAR_W = 8,
    parameter int IDX_W  = 5
);
    logic [1:0]             sel;
    logic [NSRC*CHAR_W-1:0] src_data;
    logic [IDX_W-1:0]       index_char;
    logic                   en_1hz;
    logic [IDX_W-1:0]       cursor;
    logic                   sw_any;
    logic [CHAR_W-1:0]      data_char;
    logic [1:0]             active_src;
    logic                   busy;
    logic                   frame_end;
    logic                   blink_on;

    modport master (
        output sel, src_data, index_char, en_1hz, cursor, sw_any,
        input  data_char, active_src, busy, frame_end, blink_on
    );

    modport slave (
        input  sel, src_data, index_char, en_1hz, cursor, sw_any,
        output data_char, active_src, busy, frame_end, blink_on
    );
endinterface

// File: rtl/lcd_frame_tracker.sv
// Watches the lcd_driver character index and flags the FRAME_LAST->0 wrap,
// both combinationally (wrap) and as a registered one-cycle pulse (frame_end).
module lcd_frame_tracker
    import lcd_src_scheduler_pkg::*;
#(
    parameter int IDX_W      = 5,
    parameter int FRAME_LAST = lcd_src_scheduler_pkg::FRAME_LAST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index_char,
    output logic             wrap,
    output logic             frame_end
);

    logic [IDX_W-1:0] idx_q;

    // Only the exact last->first step counts; any other jump back to 0 is ignored.
    assign wrap = (idx_q == IDX_W'(FRAME_LAST)) && (index_char == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= '0;
            frame_end <= 1'b0;
        end else begin
            idx_q     <= index_char;
            frame_end <= wrap;
        end
    end

endmodule

// File: rtl/lcd_src_scheduler.sv
// Shares the lcd_driver character path among NSRC sources, switching only on frame
// boundaries with one blank frame in between, plus a cursor-blink overlay.
module lcd_src_scheduler
    import lcd_src_scheduler_pkg::*;
#(
    parameter int                NSRC       = 4,
    parameter int                CHAR_W     = 8,
    parameter int                IDX_W      = 5,
    parameter int                FRAME_LAST = lcd_src_scheduler_pkg::FRAME_LAST,
    parameter logic [CHAR_W-1:0] BLANK_CHAR = CHAR_W'(lcd_src_scheduler_pkg::BLANK_CHAR),
    parameter int                BLINK_SRC  = int'(SRC_SET)
) (
    input  logic                clk,
    input  logic                rst,
    lcd_src_scheduler_if.slave  bus
);

    sched_state_t      state_q, state_d;
    logic [1:0]        target_q, target_d;
    logic [1:0]        active_q, active_d;
    logic [1:0]        sel_n;
    logic [1:0]        disp_src;
    logic              blink_q;
    logic              wrap;
    logic              frame_end_w;
    logic              entering_blank;
    logic              leaving_blank;
    logic              cursor_hit;
    logic [CHAR_W-1:0] data_w;

    assign sel_n = (int'(bus.sel) < NSRC) ? bus.sel : SRC_WATCH;

    lcd_frame_tracker #(
        .IDX_W      (IDX_W),
        .FRAME_LAST (FRAME_LAST)
    ) u_frame_tracker (
        .clk        (clk),
        .rst        (rst),
        .index_char (bus.index_char),
        .wrap       (wrap),
        .frame_end  (frame_end_w)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SHOW;
            target_q <= SRC_WATCH;
            active_q <= SRC_WATCH;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            active_q <= active_d;
            // A source change or a held key always leaves the cursor visible.
            if ((active_d != active_q) || bus.sw_any) begin
                blink_q <= 1'b0;
            end else if (bus.en_1hz) begin
                blink_q <= ~blink_q;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        active_d = active_q;
        unique case (state_q)
            SHOW: begin
                if (sel_n != active_q) begin
                    target_d = sel_n;
                    state_d  = PEND;
                end
            end
            PEND: begin
                if (sel_n == active_q) begin
                    state_d = SHOW;
                end else begin
                    target_d = sel_n;
                    if (wrap) begin
                        state_d = BLANK;
                    end
                end
            end
            BLANK: begin
                target_d = sel_n;
                if (wrap) begin
                    active_d = target_q;
                    state_d  = SHOW;
                end
            end
            default: state_d = SHOW;
        endcase
    end

    // On the wrap that ends the blank frame, index 0 already belongs to the new source.
    always_comb begin
        entering_blank = (state_q == PEND) && (sel_n != active_q) && wrap;
        leaving_blank  = (state_q == BLANK) && wrap;
        disp_src       = leaving_blank ? target_q : active_q;
        cursor_hit     = (disp_src == 2'(BLINK_SRC)) && (disp_src == active_q) && blink_q
                         && (bus.index_char == bus.cursor);
        data_w         = bus.src_data[disp_src*CHAR_W +: CHAR_W];
        if (((state_q == BLANK) && !leaving_blank) || entering_blank || cursor_hit) begin
            data_w = BLANK_CHAR;
        end
    end

    assign bus.data_char  = data_w;
    assign bus.active_src = active_q;
    assign bus.busy       = (state_q != SHOW);
    assign bus.frame_end  = frame_end_w;
    assign bus.blink_on   = blink_q;

endmodule

// File: tb/tb_lcd_src_scheduler.sv
// Directed bench for lcd_src_scheduler: frame wrap, switching with a blank frame,
// cancel, retarget during blank, cursor blink and asynchronous reset mid-switch.
module tb_lcd_src_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         cur_idx;
    logic [1:0] sel_req;
    logic       hz_req;
    logic       sw_req;
    int         n_cmp = 0;
    int         n_bad = 0;

    lcd_src_scheduler_if #(.NSRC(4), .CHAR_W(8), .IDX_W(5)) bus ();

    lcd_src_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic next_idx();
        cur_idx = (cur_idx >= 31) ? 0 : cur_idx + 1;
        @(negedge clk);
        bus.index_char = 5'(cur_idx);
        bus.sel        = sel_req;
        bus.en_1hz     = hz_req;
        bus.sw_any     = sw_req;
        #1;
    endtask

    task automatic goto_idx(input int target);
        next_idx();
        while (cur_idx != target) next_idx();
    endtask

    task automatic pulse_hz();
        hz_req = 1'b1;
        next_idx();
        hz_req = 1'b0;
    endtask

    task automatic test_reset();
        sel_req = 2'd0; hz_req = 1'b0; sw_req = 1'b0; cur_idx = 31;
        bus.sel = 2'd0; bus.en_1hz = 1'b0; bus.sw_any = 1'b0;
        bus.src_data = 32'h44434241; bus.cursor = 5'd7; bus.index_char = 5'd31;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.active_src !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_active got %0d want 0", bus.active_src); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.blink_on !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_blink got %b want 0", bus.blink_on); end
        n_cmp++; if (bus.frame_end !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_frame_end got %b want 0", bus.frame_end); end
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            next_idx();
            n_cmp++; if (bus.data_char !== 8'h41 || bus.busy !== 1'b0 || bus.active_src !== 2'd0) begin
                n_bad++; $display("[TB] FAIL reset_frame idx=%0d got data=%h busy=%b src=%0d want 41/0/0",
                                  cur_idx, bus.data_char, bus.busy, bus.active_src);
            end
        end
    endtask

    task automatic test_frame_end();
        next_idx();
        n_cmp++; if (bus.frame_end !== 1'b0) begin n_bad++; $display("[TB] FAIL fe_on_wrap got %b want 0", bus.frame_end); end
        next_idx();
        n_cmp++; if (bus.frame_end !== 1'b1) begin n_bad++; $display("[TB] FAIL fe_after_wrap got %b want 1", bus.frame_end); end
        next_idx();
        n_cmp++; if (bus.frame_end !== 1'b0) begin n_bad++; $display("[TB] FAIL fe_single got %b want 0", bus.frame_end); end
        goto_idx(20);
        cur_idx = 31;
        next_idx();
        next_idx();
        n_cmp++; if (bus.frame_end !== 1'b0) begin n_bad++; $display("[TB] FAIL fe_jump got %b want 0", bus.frame_end); end
        goto_idx(31);
    endtask

    task automatic test_cancel();
        goto_idx(4);
        sel_req = 2'd1;
        next_idx();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL cancel_req_busy got %b want 0", bus.busy); end
        for (int i = 6; i < 20; i++) begin
            next_idx();
            n_cmp++; if (bus.busy !== 1'b1 || bus.data_char !== 8'h41) begin
                n_bad++; $display("[TB] FAIL cancel_pend idx=%0d got busy=%b data=%h want 1/41", cur_idx, bus.busy, bus.data_char);
            end
        end
        sel_req = 2'd0;
        next_idx();
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL cancel_idx20_busy got %b want 1", bus.busy); end
        for (int i = 0; i < 43; i++) begin
            next_idx();
            n_cmp++; if (bus.busy !== 1'b0 || bus.data_char !== 8'h41 || bus.active_src !== 2'd0) begin
                n_bad++; $display("[TB] FAIL cancel_after idx=%0d got busy=%b data=%h src=%0d want 0/41/0",
                                  cur_idx, bus.busy, bus.data_char, bus.active_src);
            end
        end
    endtask

    task automatic test_switch();
        goto_idx(9);
        sel_req = 2'd1;
        next_idx();
        n_cmp++; if (bus.busy !== 1'b0 || bus.data_char !== 8'h41) begin
            n_bad++; $display("[TB] FAIL switch_req got busy=%b data=%h want 0/41", bus.busy, bus.data_char);
        end
        for (int i = 11; i < 32; i++) begin
            next_idx();
            n_cmp++; if (bus.busy !== 1'b1 || bus.data_char !== 8'h41 || bus.active_src !== 2'd0) begin
                n_bad++; $display("[TB] FAIL switch_pend idx=%0d got busy=%b data=%h src=%0d want 1/41/0",
                                  cur_idx, bus.busy, bus.data_char, bus.active_src);
            end
        end
        for (int i = 0; i < 32; i++) begin
            next_idx();
            n_cmp++; if (bus.busy !== 1'b1 || bus.data_char !== 8'h20 || bus.active_src !== 2'd0) begin
                n_bad++; $display("[TB] FAIL switch_blank idx=%0d got busy=%b data=%h src=%0d want 1/20/0",
                                  cur_idx, bus.busy, bus.data_char, bus.active_src);
            end
            if (i == 1) begin
                n_cmp++; if (bus.frame_end !== 1'b1) begin n_bad++; $display("[TB] FAIL switch_frame_end got %b want 1", bus.frame_end); end
            end
        end
        next_idx();
        n_cmp++; if (bus.data_char !== 8'h42) begin n_bad++; $display("[TB] FAIL switch_idx0 got %h want 42", bus.data_char); end
        for (int i = 1; i < 32; i++) begin
            next_idx();
            n_cmp++; if (bus.busy !== 1'b0 || bus.data_char !== 8'h42 || bus.active_src !== 2'd1) begin
                n_bad++; $display("[TB] FAIL switch_new idx=%0d got busy=%b data=%h src=%0d want 0/42/1",
                                  cur_idx, bus.busy, bus.data_char, bus.active_src);
            end
        end
    endtask

    task automatic test_blink();
        goto_idx(7);
        n_cmp++; if (bus.data_char !== 8'h42 || bus.blink_on !== 1'b0) begin
            n_bad++; $display("[TB] FAIL blink_init got data=%h blink=%b want 42/0", bus.data_char, bus.blink_on);
        end
        pulse_hz();
        goto_idx(6);
        n_cmp++; if (bus.data_char !== 8'h42 || bus.blink_on !== 1'b1) begin
            n_bad++; $display("[TB] FAIL blink_other_idx got data=%h blink=%b want 42/1", bus.data_char, bus.blink_on);
        end
        next_idx();
        n_cmp++; if (bus.data_char !== 8'h20) begin n_bad++; $display("[TB] FAIL blink_off_phase got %h want 20", bus.data_char); end
        pulse_hz();
        goto_idx(7);
        n_cmp++; if (bus.data_char !== 8'h42 || bus.blink_on !== 1'b0) begin
            n_bad++; $display("[TB] FAIL blink_on_phase got data=%h blink=%b want 42/0", bus.data_char, bus.blink_on);
        end
        sw_req = 1'b1;
        pulse_hz();
        goto_idx(7);
        n_cmp++; if (bus.data_char !== 8'h42 || bus.blink_on !== 1'b0) begin
            n_bad++; $display("[TB] FAIL blink_sw_ignore got data=%h blink=%b want 42/0", bus.data_char, bus.blink_on);
        end
        sw_req = 1'b0;
        pulse_hz();
        goto_idx(7);
        n_cmp++; if (bus.data_char !== 8'h20 || bus.blink_on !== 1'b1) begin
            n_bad++; $display("[TB] FAIL blink_rearm got data=%h blink=%b want 20/1", bus.data_char, bus.blink_on);
        end
        sw_req = 1'b1;
        next_idx();
        goto_idx(7);
        n_cmp++; if (bus.data_char !== 8'h42 || bus.blink_on !== 1'b0) begin
            n_bad++; $display("[TB] FAIL blink_sw_force got data=%h blink=%b want 42/0", bus.data_char, bus.blink_on);
        end
        sw_req = 1'b0;
    endtask

    task automatic test_retarget_in_blank();
        logic [7:0] exp;
        pulse_hz();
        goto_idx(2);
        n_cmp++; if (bus.blink_on !== 1'b1) begin n_bad++; $display("[TB] FAIL retarget_blink_pre got %b want 1", bus.blink_on); end
        sel_req = 2'd2;
        next_idx();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL retarget_req_busy got %b want 0", bus.busy); end
        for (int i = 4; i < 32; i++) begin
            next_idx();
            exp = (cur_idx == 7) ? 8'h20 : 8'h42;
            n_cmp++; if (bus.busy !== 1'b1 || bus.data_char !== exp) begin
                n_bad++; $display("[TB] FAIL retarget_pend idx=%0d got busy=%b data=%h want 1/%h", cur_idx, bus.busy, bus.data_char, exp);
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (i == 10) sel_req = 2'd3;
            next_idx();
            n_cmp++; if (bus.busy !== 1'b1 || bus.data_char !== 8'h20 || bus.active_src !== 2'd1) begin
                n_bad++; $display("[TB] FAIL retarget_blank idx=%0d got busy=%b data=%h src=%0d want 1/20/1",
                                  cur_idx, bus.busy, bus.data_char, bus.active_src);
            end
        end
        next_idx();
        n_cmp++; if (bus.data_char !== 8'h44) begin n_bad++; $display("[TB] FAIL retarget_idx0 got %h want 44", bus.data_char); end
        for (int i = 0; i < 63; i++) begin
            next_idx();
            n_cmp++; if (bus.busy !== 1'b0 || bus.data_char !== 8'h44 || bus.active_src !== 2'd3 || bus.blink_on !== 1'b0) begin
                n_bad++; $display("[TB] FAIL retarget_new idx=%0d got busy=%b data=%h src=%0d blink=%b want 0/44/3/0",
                                  cur_idx, bus.busy, bus.data_char, bus.active_src, bus.blink_on);
            end
        end
    endtask

    task automatic test_reset_mid_blank();
        goto_idx(1);
        sel_req = 2'd0;
        next_idx();
        goto_idx(31);
        next_idx();
        goto_idx(15);
        n_cmp++; if (bus.busy !== 1'b1 || bus.data_char !== 8'h20) begin
            n_bad++; $display("[TB] FAIL rst_pre_blank got busy=%b data=%h want 1/20", bus.busy, bus.data_char);
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.active_src !== 2'd0 || bus.busy !== 1'b0 || bus.data_char !== 8'h41 || bus.frame_end !== 1'b0 || bus.blink_on !== 1'b0) begin
            n_bad++; $display("[TB] FAIL rst_async got src=%0d busy=%b data=%h fe=%b blink=%b want 0/0/41/0/0",
                              bus.active_src, bus.busy, bus.data_char, bus.frame_end, bus.blink_on);
        end
        next_idx();
        next_idx();
        rst = 1'b1;
        for (int i = 0; i < 47; i++) begin
            next_idx();
            n_cmp++; if (bus.busy !== 1'b0 || bus.data_char !== 8'h41 || bus.active_src !== 2'd0) begin
                n_bad++; $display("[TB] FAIL rst_after idx=%0d got busy=%b data=%h src=%0d want 0/41/0",
                                  cur_idx, bus.busy, bus.data_char, bus.active_src);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_end();
        test_cancel();
        test_switch();
        test_blink();
        test_retarget_in_blank();
        test_reset_mid_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/lcd_src_scheduler.md
Name: lcd_src_scheduler

Overview:
- Shares the single lcd_driver character path among up to NSRC character sources: watch, watch-set, and future alarm and stopwatch modes.
- Changes the visible source only at frame boundaries and inserts one blank frame between sources, so the panel never shows a frame mixed from two modes.
- Applies a cursor-blink overlay to the set-mode source.
- Sits between the mode_* blocks and lcd_driver, replacing the top-level dip_sw mux.

Parameters:
- NSRC, 4, number of character sources (2..4).
- CHAR_W, 8, character width.
- IDX_W, 5, index_char width.
- FRAME_LAST, 31, last character index of a frame.
- BLANK_CHAR, 8'h20, character driven during blank frames and blink-off.
- BLINK_SRC, 1, source index that receives the cursor-blink overlay.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- sel  in  2  requested source, level; values >= NSRC are treated as 0
- src_data  in  NSRC*CHAR_W  packed source characters; source k occupies bits [k*CHAR_W +: CHAR_W]
- index_char  in  IDX_W  character index currently requested by lcd_driver
- en_1hz  in  1  one-cycle 1 Hz tick
- cursor  in  IDX_W  cursor position from the set-mode block
- sw_any  in  1  OR of sw_in; high while any key is pressed
- data_char  out  CHAR_W  character to lcd_driver
- active_src  out  2  source currently displayed
- busy  out  1  high when the state is not SHOW
- frame_end  out  1  one-cycle pulse at frame wrap
- blink_on  out  1  current blink phase; 1 = cursor blanked

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is asynchronous and active-low.
  - Reset values: state=SHOW, active_src=0, target=0, idx_q=0, blink_on=0, frame_end=0, busy=0.
- Frame detection:
  - idx_q registers index_char every clk.
  - wrap = (idx_q==FRAME_LAST) && (index_char==0). This is combinational.
  - frame_end is wrap registered, so it pulses 1 cycle after the wrap cycle.
  - An index jump other than FRAME_LAST->0 is not a wrap.
- Request decode: sel_n = (sel<NSRC) ? sel : 0.
- State machine (states SHOW, PEND, BLANK):
  - SHOW: if sel_n != active_src, set target<=sel_n and go to PEND.
  - PEND:
    - if sel_n==active_src, cancel and return to SHOW;
    - else target<=sel_n (retarget, no extra wait);
    - on wrap, go to BLANK. A wrap and a retarget in the same cycle use the new sel_n.
  - BLANK:
    - target<=sel_n every cycle;
    - on the next wrap, active_src<=target and go to SHOW;
    - if target then differs from sel_n, the normal SHOW->PEND path follows. No second blank is inserted for a request that arrives during BLANK.
  - Minimum switch latency: one full blank frame (FRAME_LAST+1 indices) after the first wrap following the request.
- data_char (combinational, zero latency from index_char so the lcd_driver timing is unchanged):
  - state BLANK, or the wrap cycle that enters BLANK: BLANK_CHAR.
  - active_src==BLINK_SRC && blink_on && index_char==cursor: BLANK_CHAR.
  - otherwise: src_data slice of active_src.
  - PEND shows active_src unchanged.
- Blink:
  - blink_on toggles on en_1hz.
  - While sw_any=1, blink_on is forced to 0 (cursor visible) and en_1hz is ignored.
  - blink_on resets to 0 on any active_src change.
- busy = (state != SHOW).
- Reset mid-switch: immediately returns to SHOW with source 0; no blank frame is produced.

Decomposition:
- Shared package holds:
  - state encoding (SHOW=2'd0, PEND=2'd1, BLANK=2'd2);
  - BLANK_CHAR;
  - FRAME_LAST;
  - source index constants SRC_WATCH=0, SRC_SET=1, SRC_ALARM=2, SRC_STOPW=3.
- One sub-module, lcd_frame_tracker: owns idx_q and produces the wrap / frame_end pulses. It is reusable by future LCD blocks.
- Source muxing, the FSM and blink stay in the top module.

Test Plan:
- Reset with sel=0 and src0 all 8'h41, index_char cycling 0..31 -> data_char=8'h41 on every index, active_src=0, busy=0.
- sel 0->1 requested at index 10 -> PEND until the 31->0 wrap, then indices 0..31 all 8'h20 with busy=1, then active_src=1, src1 data shown from index 0, busy=0.
- sel 0->1 at index 5, then 1->0 at index 20 of the same frame -> cancel, no blank frame, active_src stays 0, busy falls at index 20.
- sel 0->2 then 2->3 during BLANK -> after a single blank frame active_src=3, with no second blank frame.
- active_src=1, cursor=7, two en_1hz pulses -> index 7 alternates 8'h20 / src1 char; sw_any=1 held -> index 7 always shows the src1 char.
- rst asserted low in the middle of BLANK -> outputs return to reset values asynchronously; active_src=0 and the src0 data is shown after release.
